instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit word, substitutes
// a NOP on illegal field sets, and buffers results in a DEPTH-entry FIFO.
`default_nettype none

module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic [6:0]  InOpcode,
    input  logic [2:0]  InFunct3,
    input  logic [6:0]  InFunct7,
    input  logic [4:0]  InRd,
    input  logic [4:0]  InRs1,
    input  logic [4:0]  InRs2,
    input  logic [31:0] InImm,
    input  logic        Flush,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic        OutErr,
    output logic [15:0] ErrCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_FENCE    = 7'b0001111;
    localparam logic [6:0]  OP_MATH_IMM = 7'b0010011;
    localparam logic [6:0]  OP_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [6:0]  OP_MATH     = 7'b0110011;
    localparam logic [6:0]  OP_LUI      = 7'b0110111;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0]  F7_BASE     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic [31:0]   enc_word_d;
    logic          enc_err_d;
    logic [31:0]   packed_d;
    logic          ok_i_d;
    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   err_cnt_q;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ok_i_d = (InImm[31:11] == {21{InImm[31]}});

    always_comb begin
        packed_d  = '0;
        enc_err_d = 1'b0;
        case (InOpcode)
            OP_MATH: begin
                packed_d  = {InFunct7, InRs2, InRs1, InFunct3, InRd, InOpcode};
                enc_err_d = !((InFunct7 == F7_BASE) ||
                              ((InFunct7 == F7_ALT) && ((InFunct3 == 3'b000) || (InFunct3 == 3'b101))));
            end
            OP_MATH_IMM: begin
                if ((InFunct3 == 3'b001) || (InFunct3 == 3'b101)) begin
                    // Shift-immediate: funct7 occupies imm[11:5], shamt is 5 bits.
                    packed_d  = {InFunct7, InImm[4:0], InRs1, InFunct3, InRd, InOpcode};
                    enc_err_d = (|InImm[31:5]) ||
                                ((InFunct7 != F7_BASE) && (InFunct7 != F7_ALT)) ||
                                ((InFunct7 == F7_ALT) && (InFunct3 == 3'b001));
                end else begin
                    packed_d  = {InImm[11:0], InRs1, InFunct3, InRd, InOpcode};
                    enc_err_d = !ok_i_d;
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                packed_d  = {InImm[11:0], InRs1, InFunct3, InRd, InOpcode};
                enc_err_d = !ok_i_d;
            end
            OP_STORE: begin
                packed_d  = {InImm[11:5], InRs2, InRs1, InFunct3, InImm[4:0], InOpcode};
                enc_err_d = !ok_i_d;
            end
            OP_BRANCH: begin
                packed_d  = {InImm[12], InImm[10:5], InRs2, InRs1, InFunct3,
                             InImm[4:1], InImm[11], InOpcode};
                enc_err_d = (InImm[31:12] != {20{InImm[31]}}) || InImm[0];
            end
            OP_LUI, OP_AUIPC: begin
                packed_d  = {InImm[31:12], InRd, InOpcode};
                enc_err_d = (InImm[11:0] != 12'h000);
            end
            OP_JAL: begin
                packed_d  = {InImm[20], InImm[10:1], InImm[11], InImm[19:12], InRd, InOpcode};
                enc_err_d = (InImm[31:20] != {12{InImm[31]}}) || InImm[0];
            end
            default: enc_err_d = 1'b1;
        endcase
        enc_word_d = enc_err_d ? NOP : packed_d;
    end

    assign InReady  = (count_q != CW'(DEPTH)) && !Flush && !Rst;
    assign OutValid = (count_q != '0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady && !Flush;
    assign OutInstr = OutValid ? mem_q[rptr_q][31:0] : 32'h0;
    assign OutErr   = OutValid ? mem_q[rptr_q][32]   : 1'b0;
    assign ErrCount = err_cnt_q;

    // Storage needs no reset: OutValid gates everything read from it.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wptr_q] <= {enc_err_d, enc_word_d};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (Flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= ptr_inc(wptr_q);
                if (pop)  rptr_q <= ptr_inc(rptr_q);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);
            end
            if (push && enc_err_d && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
